// File: rtl/pulse_seq_pkg.sv
// Shared types for the CPMG pulse sequencer: FSM states, configuration payload
// and a saturating adder used for the doubled inter-pulse gap.
package pulse_seq_pkg;

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned CPMG_W = 8;
    localparam int unsigned BLK_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_P1,
        ST_GAP,
        ST_P2,
        ST_TAIL
    } state_e;

    typedef struct packed {
        logic [CNT_W-1:0]  period;
        logic [CNT_W-1:0]  p1width;
        logic [CNT_W-1:0]  delay;
        logic [CNT_W-1:0]  p2width;
        logic [CPMG_W-1:0] cpmg;
        logic [BLK_W-1:0]  block;
    } cfg_t;

    // a + b evaluated one bit wider, clamped to all-ones on overflow
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter timing one sequencer phase; expire_c marks the last
// cycle of the loaded length.
module seq_timer
    import pulse_seq_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire_c
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_c = (count_q <= CNT_W'(1));

endmodule

// File: rtl/cpmg_pulse_seq.sv
// Repeating spin-echo / CPMG generator: P1 then cpmg x P2 per period, with SYNC,
// receiver INHIB and a block divider; config is double-buffered to period starts.
module cpmg_pulse_seq
    import pulse_seq_pkg::*;
#(
    parameter int unsigned SYNC_LEN = 16,
    parameter int unsigned GUARD    = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              run,
    input  logic              cfg_load,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_p1width,
    input  logic [CNT_W-1:0]  cfg_delay,
    input  logic [CNT_W-1:0]  cfg_p2width,
    input  logic [CPMG_W-1:0] cfg_cpmg,
    input  logic [BLK_W-1:0]  cfg_block,
    output logic              sync_on,
    output logic              pulse_on,
    output logic              inhib,
    output logic              busy,
    output logic              period_done
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CPMG_W-1:0] rem_q, rem_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  guard_q, guard_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    cfg_t              act_q, act_d;
    cfg_t              pend_q, pend_d;
    logic              pend_valid_q, pend_valid_d;
    logic              sync_on_q, sync_on_d;
    logic              pulse_on_q, pulse_on_d;
    logic              inhib_q, inhib_d;
    logic              busy_q, busy_d;
    logic              period_done_q, period_done_d;

    cfg_t              cfg_c;
    logic [CNT_W-1:0]  eff_last_c;
    logic [CNT_W-1:0]  gap2_c;
    logic              rollover_c, start_c, has_p2_c;
    logic              after_p1_c, p1_pulsed_c, after_p2_c, after_gap_c;
    logic              tmr_load_c, tmr_expire_c;
    logic [CNT_W-1:0]  tmr_val_c;

    seq_timer u_timer (
        .clk      (clk),
        .resetn   (resetn),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .expire_c (tmr_expire_c)
    );

    assign eff_last_c = (act_q.period < CNT_W'(2)) ? CNT_W'(1) : act_q.period - CNT_W'(1);
    assign rollover_c = (state_q != ST_IDLE) && (cnt_q == eff_last_c);
    assign start_c    = run && ((state_q == ST_IDLE) || rollover_c);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        done_d        = done_q;
        guard_d       = (guard_q != '0) ? guard_q - CNT_W'(1) : guard_q;
        blk_d         = blk_q;
        act_d         = act_q;
        pend_d        = pend_q;
        pend_valid_d  = pend_valid_q;
        cfg_c         = act_q;
        tmr_load_c    = 1'b0;
        tmr_val_c     = '0;
        after_p1_c    = 1'b0;
        p1_pulsed_c   = 1'b0;
        after_p2_c    = 1'b0;
        after_gap_c   = 1'b0;

        // Period boundary preempts whatever phase the sequence is in
        if (start_c) begin
            if (pend_valid_q) begin
                cfg_c        = pend_q;
                pend_valid_d = 1'b0;
            end
            act_d   = cfg_c;
            cnt_d   = '0;
            done_d  = 1'b0;
            guard_d = '0;
            blk_d   = ((state_q == ST_IDLE) || (blk_q >= cfg_c.block)) ? '0 : blk_q + BLK_W'(1);
            if (cfg_c.p1width != '0) begin
                state_d    = ST_P1;
                tmr_load_c = 1'b1;
                tmr_val_c  = cfg_c.p1width;
            end else begin
                after_p1_c = 1'b1;
            end
        end else if (rollover_c) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            if (state_q != ST_IDLE) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            case (state_q)
                ST_P1: begin
                    after_p1_c  = tmr_expire_c;
                    p1_pulsed_c = tmr_expire_c;
                end
                ST_GAP:  after_gap_c = tmr_expire_c;
                ST_P2:   after_p2_c  = tmr_expire_c;
                default: ;
            endcase
        end

        // A load on a period-start cycle lands in pending for the following period
        if (cfg_load) begin
            pend_d.period  = cfg_period;
            pend_d.p1width = cfg_p1width;
            pend_d.delay   = cfg_delay;
            pend_d.p2width = cfg_p2width;
            pend_d.cpmg    = cfg_cpmg;
            pend_d.block   = cfg_block;
            pend_valid_d   = 1'b1;
        end

        has_p2_c = (cfg_c.cpmg != '0) && (cfg_c.p2width != '0);
        gap2_c   = sat_add(cfg_c.delay, cfg_c.delay);

        // Zero-length phases resolve in the same cycle so they never stall
        if (after_p1_c) begin
            rem_d = cfg_c.cpmg;
            if (!has_p2_c) begin
                done_d = 1'b1;
                if (p1_pulsed_c) begin
                    guard_d = CNT_W'(GUARD);
                end
            end
            if (cfg_c.delay != '0) begin
                state_d    = ST_GAP;
                tmr_load_c = 1'b1;
                tmr_val_c  = cfg_c.delay;
            end else if (has_p2_c) begin
                state_d    = ST_P2;
                tmr_load_c = 1'b1;
                tmr_val_c  = cfg_c.p2width;
                rem_d      = cfg_c.cpmg - CPMG_W'(1);
            end else begin
                state_d = ST_TAIL;
            end
        end

        if (after_p2_c) begin
            if (rem_q == '0) begin
                done_d  = 1'b1;
                guard_d = CNT_W'(GUARD);
            end
            if (gap2_c != '0) begin
                state_d    = ST_GAP;
                tmr_load_c = 1'b1;
                tmr_val_c  = gap2_c;
            end else if (rem_q != '0) begin
                state_d    = ST_P2;
                tmr_load_c = 1'b1;
                tmr_val_c  = cfg_c.p2width;
                rem_d      = rem_q - CPMG_W'(1);
            end else begin
                state_d = ST_TAIL;
            end
        end

        if (after_gap_c) begin
            if ((rem_q != '0) && (cfg_c.p2width != '0)) begin
                state_d    = ST_P2;
                tmr_load_c = 1'b1;
                tmr_val_c  = cfg_c.p2width;
                rem_d      = rem_q - CPMG_W'(1);
            end else begin
                state_d = ST_TAIL;
            end
        end
    end

    // Outputs trail the phase state by one registered cycle
    always_comb begin
        pulse_on_d    = ((state_q == ST_P1) || (state_q == ST_P2)) && (blk_q == '0) && !rollover_c;
        sync_on_d     = (state_q != ST_IDLE) && (cnt_q < CNT_W'(SYNC_LEN));
        inhib_d       = (state_q != ST_IDLE) && (!done_q || (guard_q != '0));
        busy_d        = (state_q != ST_IDLE);
        period_done_d = rollover_c;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            done_q        <= 1'b0;
            guard_q       <= '0;
            blk_q         <= '0;
            act_q         <= '0;
            pend_q        <= '0;
            pend_valid_q  <= 1'b0;
            sync_on_q     <= 1'b0;
            pulse_on_q    <= 1'b0;
            inhib_q       <= 1'b0;
            busy_q        <= 1'b0;
            period_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            done_q        <= done_d;
            guard_q       <= guard_d;
            blk_q         <= blk_d;
            act_q         <= act_d;
            pend_q        <= pend_d;
            pend_valid_q  <= pend_valid_d;
            sync_on_q     <= sync_on_d;
            pulse_on_q    <= pulse_on_d;
            inhib_q       <= inhib_d;
            busy_q        <= busy_d;
            period_done_q <= period_done_d;
        end
    end

    assign sync_on     = sync_on_q;
    assign pulse_on    = pulse_on_q;
    assign inhib       = inhib_q;
    assign busy        = busy_q;
    assign period_done = period_done_q;

endmodule

// File: tb/tb_cpmg_pulse_seq.sv
// Directed bench for cpmg_pulse_seq; cycle 0 is the first cycle sync_on is high.
module tb_cpmg_pulse_seq;

    logic        clk;
    logic        resetn;
    logic        run;
    logic        cfg_load;
    logic [31:0] cfg_period;
    logic [31:0] cfg_p1width;
    logic [31:0] cfg_delay;
    logic [31:0] cfg_p2width;
    logic [7:0]  cfg_cpmg;
    logic [7:0]  cfg_block;
    logic        sync_on;
    logic        pulse_on;
    logic        inhib;
    logic        busy;
    logic        period_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    cpmg_pulse_seq #(.SYNC_LEN(16), .GUARD(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .run         (run),
        .cfg_load    (cfg_load),
        .cfg_period  (cfg_period),
        .cfg_p1width (cfg_p1width),
        .cfg_delay   (cfg_delay),
        .cfg_p2width (cfg_p2width),
        .cfg_cpmg    (cfg_cpmg),
        .cfg_block   (cfg_block),
        .sync_on     (sync_on),
        .pulse_on    (pulse_on),
        .inhib       (inhib),
        .busy        (busy),
        .period_done (period_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic obs, input logic req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, req, cyc);
        end
    endtask

    task automatic chk_out(input string tag, input logic p, input logic s,
                           input logic i, input logic d);
        chk({tag, "_pulse"}, pulse_on, p);
        chk({tag, "_sync"}, sync_on, s);
        chk({tag, "_inhib"}, inhib, i);
        chk({tag, "_pdone"}, period_done, d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load_cfg(input int per, input int p1, input int dly, input int p2,
                            input int cp, input int blk);
        cfg_period  = 32'(per);
        cfg_p1width = 32'(p1);
        cfg_delay   = 32'(dly);
        cfg_p2width = 32'(p2);
        cfg_cpmg    = 8'(cp);
        cfg_block   = 8'(blk);
        cfg_load    = 1'b1;
        tick();
        cfg_load    = 1'b0;
    endtask

    task automatic start_run();
        run = 1'b1;
        tick();
        tick();
        cyc = 0;
    endtask

    task automatic stop_and_idle(input string tag);
        run = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (busy === 1'b0) break;
            tick();
        end
        chk({tag, "_idle_busy"}, busy, 1'b0);
        chk_out({tag, "_idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // P1 of width w, P2 after tau=10 for 8 cycles, second P2 after 2*tau
    function automatic logic win(input int k, input int w);
        return (k < w) || ((k >= w + 10) && (k < w + 18)) || ((k >= w + 38) && (k < w + 46));
    endfunction

    initial begin
        resetn = 1'b0;
        run = 1'b0;
        cfg_load = 1'b0;
        cfg_period = '0;
        cfg_p1width = '0;
        cfg_delay = '0;
        cfg_p2width = '0;
        cfg_cpmg = '0;
        cfg_block = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_busy", busy, 1'b0);
        resetn = 1'b1;
        tick();

        // Basic CPMG period with two refocusing pulses
        load_cfg(100, 4, 10, 8, 2, 0);
        start_run();
        for (int c = 0; c <= 100; c++) begin
            int k;
            k = c % 100;
            chk_out("s1", win(k, 4), k < 16, k < 54, k == 99);
            tick();
        end
        stop_and_idle("s1");

        // P1 only
        load_cfg(20, 5, 10, 8, 0, 0);
        start_run();
        for (int c = 0; c < 40; c++) begin
            int k;
            k = c % 20;
            chk_out("s2", k < 5, k < 16, k < 9, k == 19);
            tick();
        end
        stop_and_idle("s2");

        // Block divider: pulses only in periods 0 and 3
        load_cfg(100, 4, 10, 8, 2, 2);
        start_run();
        for (int c = 0; c < 600; c++) begin
            int k;
            int p;
            k = c % 100;
            p = c / 100;
            chk_out("s3", win(k, 4) && (p == 0 || p == 3), k < 16, k < 54, k == 99);
            tick();
        end
        stop_and_idle("s3");

        // Sequence longer than period is truncated
        load_cfg(30, 4, 10, 8, 2, 0);
        start_run();
        for (int c = 0; c < 60; c++) begin
            int k;
            k = c % 30;
            chk_out("s4a", win(k, 4), k < 16, 1'b1, k == 29);
            tick();
        end
        stop_and_idle("s4a");

        // Pulse still active at rollover is forced low on that cycle
        load_cfg(16, 40, 10, 8, 0, 0);
        start_run();
        for (int c = 0; c < 32; c++) begin
            int k;
            k = c % 16;
            chk_out("s4b", k != 15, 1'b1, 1'b1, k == 15);
            tick();
        end
        stop_and_idle("s4b");

        // period = 0 behaves as a 2-cycle period
        load_cfg(0, 4, 10, 8, 0, 0);
        start_run();
        for (int c = 0; c < 8; c++) begin
            int k;
            k = c % 2;
            chk_out("s4c", k == 0, 1'b1, 1'b1, k == 1);
            tick();
        end
        stop_and_idle("s4c");

        // Double-buffered reload: mid-period and on the period-start cycle
        load_cfg(100, 4, 10, 8, 2, 0);
        start_run();
        for (int c = 0; c < 400; c++) begin
            int k;
            int p;
            int w;
            k = c % 100;
            p = c / 100;
            w = (p == 0) ? 4 : ((p <= 2) ? 9 : 2);
            chk_out("s5", win(k, w), k < 16, k < w + 50, k == 99);
            cfg_load = 1'b0;
            if (c == 2) begin
                cfg_p1width = 32'd9;
                cfg_load = 1'b1;
            end
            if (c == 198) begin
                cfg_p1width = 32'd2;
                cfg_load = 1'b1;
            end
            tick();
        end
        cfg_load = 1'b0;
        stop_and_idle("s5");

        // Asynchronous reset in the middle of a P2 pulse
        load_cfg(100, 4, 10, 8, 2, 0);
        start_run();
        for (int c = 0; c < 16; c++) tick();
        chk("s6_pre_pulse", pulse_on, 1'b1);
        resetn = 1'b0;
        #1;
        chk_out("s6_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("s6_rst_busy", busy, 1'b0);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        tick();
        cyc = 0;
        for (int c = 0; c < 8; c++) begin
            chk_out("s6", 1'b0, 1'b1, 1'b0, (c % 2) == 1);
            chk("s6_busy", busy, 1'b1);
            tick();
        end
        stop_and_idle("s6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpmg_pulse_seq.md
Name: cpmg_pulse_seq

Overview:
Parametrised successor to the fixed two-pulse generator. Produces a repeating spin-echo / CPMG sequence: one P1 pulse, then CPMG_N P2 refocusing pulses, with a per-period SYNC strobe and a receiver INHIB gate. Sits on the PLL clock domain, downstream of the UART control block. Configuration is double-buffered so that reloads take effect only at period boundaries.

Parameters:
CNT_W, 32, width of all timing fields and counters, in clk cycles
CPMG_W, 8, width of the P2 repeat count
SYNC_LEN, 16, SYNC high time in cycles
GUARD, 4, INHIB hold-over in cycles after the last pulse ends
BLK_W, 8, width of the block-divider count

Ports:
clk  in  1  PLL clock; all logic on rising edge
resetn  in  1  asynchronous active-low reset
run  in  1  level; high = generate periods
cfg_load  in  1  one-cycle strobe; latch the cfg_* inputs into the pending set
cfg_period  in  CNT_W  period length in cycles
cfg_p1width  in  CNT_W  P1 width
cfg_delay  in  CNT_W  tau: gap from P1 end to first P2 start
cfg_p2width  in  CNT_W  P2 width
cfg_cpmg  in  CPMG_W  number of P2 pulses (0 = P1 only)
cfg_block  in  BLK_W  0 = every period pulsed; N>0 = pulse only periods where index mod (N+1) == 0
sync_on  out  1  SYNC strobe
pulse_on  out  1  switch drive (P1 OR P2)
inhib  out  1  receiver protect
busy  out  1  high while not IDLE
period_done  out  1  one-cycle strobe on the last cycle of each period

Behaviour:
- Reset (async, resetn=0): all outputs 0; FSM = IDLE; counters = 0; pending and active config = 0; pend_valid = 0.
- cfg_load: copies the cfg_* inputs into the pending set and sets pend_valid. The active set is updated from pending at each period start, and only if pend_valid is set; pend_valid then clears. A cfg_load on the same cycle as a period start goes to pending and is applied at the next period start.
- Effective period: eff_per = max(active period, 2).
- FSM states: IDLE, P1, GAP, P2, TAIL.
  - IDLE -> P1 when run=1. Period start happens on this transition; outputs register one cycle after run rises.
  - P1: lasts p1width cycles; if p1width = 0, takes 0 cycles in P1.
  - P1 -> GAP with gap length = delay.
  - GAP -> P2 when the gap count expires, if P2 pulses remain; otherwise GAP -> TAIL.
  - P2: lasts p2width cycles.
  - P2 -> GAP with gap length = 2*delay, computed at CNT_W+1 bits and saturated to all-ones.
  - TAIL: wait for period end.
- Period counter: runs 0..eff_per-1 independently of the FSM.
  - At eff_per-1: period_done=1.
  - Next cycle: if run=1, restart at P1 (new period start); else go to IDLE.
  - Rollover preempts any state. A sequence longer than the period is truncated, and pulse_on is forced low on the rollover cycle.
- pulse_on = (state==P1 or state==P2), ANDed with block_pass. Registered, with 1-cycle pipeline from state.
- block_pass: block counter increments each period start and wraps at cfg_block. block_pass = (count==0). Timing, sync_on and inhib are unaffected by blocking.
- sync_on: high for min(SYNC_LEN, eff_per) cycles from each period start.
- inhib:
  - Rises with period start.
  - Stays high through the last pulse cycle plus GUARD cycles, then falls.
  - If the period ends first, it stays high across the boundary.
  - When blocked, it follows the same timing.
- run deasserted mid-period: the current period completes; no new period starts; outputs are 0 in IDLE.
- Width rules: all comparisons are unsigned CNT_W; width fields of 0 produce no pulse and no stall.

Decomposition:
- Package pulse_seq_pkg holds the state enum, the cfg struct (period, p1width, delay, p2width, cpmg, block), and the sat_add helper.
- One sub-module, seq_timer: a loadable down-counter with an expire flag, instantiated for the phase gap/width count.
- The period counter stays inline.

Test Plan:
1. period=100, p1=4, delay=10, p2=8, cpmg=2, run=1 -> pulse_on high at cycles 0-3, 14-21, 42-49 (relative to first sync); sync_on high cycles 0-15; inhib falls at cycle 54; period_done at cycle 99.
2. cpmg=0, p1=5, period=20 -> only P1 pulse each period; inhib high cycles 0-8.
3. block=2, same timing as scenario 1 -> pulse_on present in periods 0 and 3, absent in periods 1, 2, 4, 5; sync_on and inhib present every period.
4. period=30 with sequence ending at cycle 54 -> pulse truncated, pulse_on=0 at cycle 29, new P1 at cycle 30; period=0 -> eff_per=2.
5. cfg_load p1=4 -> p1=9 issued mid-period -> current period keeps width 4, next period uses width 9; load on the period-start cycle -> applies one period later.
6. resetn pulsed low mid-P2 -> all outputs 0 asynchronously; after release with run=1 -> clean P1 start, active config = 0, so only sync_on and period_done toggle with eff_per=2.
